load_store_unit: RTL

//  Sequences LD and STS instructions from the execute stage into the 256x8 data memory.

---
 rtl/load_store_unit_if.sv | 47 ++++
 rtl/load_store_unit.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/load_store_unit_if.sv
// -----------------------------------------------------------------------------
// load_store_unit_if
// Bundles the three handshakes around the load/store unit:
//   request  : req_valid/req_ready with req_op, req_addr, req_wdata, req_rd, flush
//   memory   : en_DM_rd, en_DM_wr, mem_addr, mem_din (to memory), mem_dout (from memory)
//   writeback: wb_valid/wb_ready with wb_rd, wb_data
//   status   : busy
// slave  modport : the load/store unit itself.
// master modport : its surroundings (execute stage, data memory, writeback).
// -----------------------------------------------------------------------------
interface load_store_unit_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int REG_W  = 3
);
  logic              req_valid;
  logic              req_ready;
  logic              req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [REG_W-1:0]  req_rd;
  logic              flush;
  logic              en_DM_rd;
  logic              en_DM_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;
  logic              wb_valid;
  logic              wb_ready;
  logic [REG_W-1:0]  wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              busy;

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, req_rd, flush,
    input  mem_dout, wb_ready,
    output req_ready, en_DM_rd, en_DM_wr, mem_addr, mem_din,
    output wb_valid, wb_rd, wb_data, busy
  );

  modport master (
    output req_valid, req_op, req_addr, req_wdata, req_rd, flush,
    output mem_dout, wb_ready,
    input  req_ready, en_DM_rd, en_DM_wr, mem_addr, mem_din,
    input  wb_valid, wb_rd, wb_data, busy
  );
endinterface

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// Sequences LD / STS requests from the execute stage into a 256x8 data memory
// with a registered read port, and returns load results to writeback.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : load_store_unit_if.slave (request, memory and writeback handshakes)
// Flow: IDLE -> ACCESS (enables high one cycle) -> IDLE for a store, or
//       -> CAPTURE (memory data arriving) -> WB (hold until wb_ready) for a load.
// -----------------------------------------------------------------------------
module load_store_unit #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int REG_W  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  load_store_unit_if.slave      bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2,
    WB      = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              op_q, op_d;
  logic [REG_W-1:0]  rd_q, rd_d;
  logic              en_rd_q, en_rd_d;
  logic              en_wr_q, en_wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic              wb_valid_q, wb_valid_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic [REG_W-1:0]  wb_rd_q, wb_rd_d;

  // Every register resets so that an access in flight is abandoned outright;
  // en_DM_wr in particular falls as soon as rst_n does, before any later edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      op_q       <= 1'b0;
      rd_q       <= '0;
      en_rd_q    <= 1'b0;
      en_wr_q    <= 1'b0;
      addr_q     <= '0;
      din_q      <= '0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
      wb_rd_q    <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      rd_q       <= rd_d;
      en_rd_q    <= en_rd_d;
      en_wr_q    <= en_wr_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      wb_valid_q <= wb_valid_d;
      wb_data_q  <= wb_data_d;
      wb_rd_q    <= wb_rd_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    rd_d       = rd_q;
    // Enables are single-cycle pulses: they only rise on the accept edge and
    // fall again at the following edge.
    en_rd_d    = 1'b0;
    en_wr_d    = 1'b0;
    // Address and write data hold their last value between accesses.
    addr_d     = addr_q;
    din_d      = din_q;
    wb_valid_d = wb_valid_q;
    wb_data_d  = wb_data_q;
    wb_rd_d    = wb_rd_q;

    unique case (state_q)
      IDLE: begin
        // flush has no meaning here: nothing is pending yet.
        if (bus.req_valid) begin
          op_d    = bus.req_op;
          rd_d    = bus.req_rd;
          addr_d  = bus.req_addr;
          din_d   = bus.req_wdata;
          en_wr_d = bus.req_op;
          en_rd_d = ~bus.req_op;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        // Memory performs the access at this edge. Stores cannot be aborted
        // because the write has already been committed by then.
        if (op_q || bus.flush) begin
          state_d = IDLE;
        end else begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else begin
          wb_data_d  = bus.mem_dout;
          wb_rd_d    = rd_q;
          wb_valid_d = 1'b1;
          state_d    = WB;
        end
      end
      WB: begin
        // flush and wb_ready leave the same way; with flush the result is
        // simply dropped rather than consumed.
        if (bus.flush || bus.wb_ready) begin
          wb_valid_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // req_ready is gated by rst_n so it drops the instant reset asserts,
  // without waiting for the state register to be observed as IDLE.
  assign bus.req_ready = (state_q == IDLE) && rst_n;
  assign bus.busy      = (state_q != IDLE);
  assign bus.en_DM_rd  = en_rd_q;
  assign bus.en_DM_wr  = en_wr_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_din   = din_q;
  assign bus.wb_valid  = wb_valid_q;
  assign bus.wb_data   = wb_data_q;
  assign bus.wb_rd     = wb_rd_q;

endmodule
